// File: rtl/feed_crc_responder.sv
// ---------------------------------------------------------------------------
// feed_crc_responder
//
// Responder end of the word feed handshake. Used as a loopback target for
// the autotest feed harness in place of a real hash core. Each accepted
// feed word is absorbed into a CRC-32/BZIP2 one bit per clock, MSB first.
// A start_hash request then finalizes and publishes the digest.
//
// Handshake: a word is accepted on a rising edge where the FSM is IDLE and
// data_ready=1. busy is high for exactly FEED_DATA_SIZE cycles afterwards.
// data_ready and start_hash are ignored while busy or after finalize; the
// producer must hold a word until it sees busy rise.
//
// Ports
//   clk         : clock, all state on rising edge
//   rst         : asynchronous active-low reset
//   data_input  : feed word (FEED_DATA_SIZE bits)
//   data_ready  : feed word valid
//   start_hash  : level request to finalize (end of message)
//   busy        : word being absorbed, no new word accepted
//   end_hash    : digest valid, held until reset
//   digest      : final CRC, reads 0 while end_hash=0
//   word_count  : accepted words, saturating
//   fsm_state   : debug view of the FSM state (IDLE=0 SHIFT=1 FINAL=2 DONE=3)
// ---------------------------------------------------------------------------
module feed_crc_responder #(
  parameter int FEED_DATA_SIZE = 8,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FEED_DATA_SIZE-1:0] data_input,
  input  logic                      data_ready,
  input  logic                      start_hash,
  output logic                      busy,
  output logic                      end_hash,
  output logic [31:0]               digest,
  output logic [CNT_W-1:0]          word_count,
  output logic [1:0]                fsm_state
);

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOR  = 32'hFFFFFFFF;

  // Bit counter only needs to reach FEED_DATA_SIZE-1.
  localparam int              BW       = (FEED_DATA_SIZE > 1) ? $clog2(FEED_DATA_SIZE) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(FEED_DATA_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state, state_nx;
  logic [FEED_DATA_SIZE-1:0] shreg;
  logic [BW-1:0]             bit_cnt;
  logic [31:0]               crc, crc_nx;
  logic [31:0]               digest_q;
  logic                      end_hash_q;
  logic                      fb;

  // Next state. data_ready wins over start_hash in IDLE; a start_hash still
  // held when IDLE is re-entered is honoured then.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (data_ready)      state_nx = SHIFT;
        else if (start_hash) state_nx = FINAL;
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) state_nx = IDLE;
      end
      FINAL:   state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // One MSB-first CRC step using the current top bit of the shift register.
  always_comb begin
    fb     = crc[31] ^ shreg[FEED_DATA_SIZE-1];
    crc_nx = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      crc        <= CRC_INIT;
      digest_q   <= '0;
      end_hash_q <= 1'b0;
      word_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (data_ready) begin
            shreg   <= data_input;
            bit_cnt <= '0;
            // Saturate rather than wrap; absorption is unaffected.
            if (word_count != {CNT_W{1'b1}}) word_count <= word_count + 1'b1;
          end
        end
        SHIFT: begin
          crc     <= crc_nx;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        FINAL: begin
          digest_q <= crc ^ CRC_XOR;
        end
        DONE: begin
          // end_hash rises one cycle after the digest register is loaded.
          end_hash_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == SHIFT);
  assign end_hash  = end_hash_q;
  assign digest    = end_hash_q ? digest_q : 32'h0;
  assign fsm_state = state;

endmodule
